// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// pipe_hazard_ctrl
// ----------------------------------------------------------------------------
// Stall/flush sequencer for a 5-stage core (IF, ID, EX, MEM, WB).
// It merges four hazard sources into one control vector per cycle. In
// priority order they are data-memory wait, multi-cycle EX op, branch
// redirect and load-use. The vector drives the enables and flushes of the PC
// and of the if_id, id_exe, exe_mem and mem_wb pipeline registers.
//
// Parameters:
//   MC_MAX_CYCLES  cycles a multi-cycle op may hold EX before timeout
//   MC_CNT_W       width of the multi-cycle wait counter (holds MC_MAX_CYCLES)
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   dec_rs1/rs2         source register indices of the ID instruction
//   dec_use_rs1/rs2     ID instruction actually reads rs1/rs2
//   exe_rd/memr/regw    destination, is-load and writes-reg flags of EX
//   exe_redirect        EX resolved a taken branch/jump this cycle
//   exe_mc_start/done   multi-cycle op entered EX / result valid
//   mem_req/mem_ack     MEM data access issued / completed
//   *_en, *_flush       pipeline register controls (combinational)
//   mc_timeout          sticky flag: a multi-cycle op ran too long
//   dbg_state           current FSM state (RUN=0, MC_WAIT=1, MEM_WAIT=2)
//
// Optional feature, macro PIPE_HAZARD_CTRL_PERF_EN:
//   perf_stall_cycles   cycles with pc_en=0 outside reset (wraps)
//   perf_flush_count    cycles with if_id_flush=1 (wraps)
//
// Stall handshake: a stage holds its register whenever its enable is 0. A
// flush loads a bubble in place of the incoming instruction when the enable
// is 1. A redirect or load-use that coincides with a stall is not acted on.
// EX is frozen, so the condition is still present on the first unstalled
// cycle.
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MC_MAX_CYCLES = 64,
  parameter int MC_CNT_W      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_use_rs1,
  input  logic       dec_use_rs2,
  input  logic [4:0] exe_rd,
  input  logic       exe_memr,
  input  logic       exe_regw,
  input  logic       exe_redirect,
  input  logic       exe_mc_start,
  input  logic       exe_mc_done,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_exe_en,
  output logic       id_exe_flush,
  output logic       exe_mem_en,
  output logic       mem_wb_en,
  output logic       mem_wb_flush,
  output logic       mc_timeout,
  output logic [1:0] dbg_state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MC_WAIT  = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_MAX_CYCLES - 1);
  localparam logic [MC_CNT_W-1:0] CNT_SAT = '1;

  logic [1:0]          state, state_nxt;
  logic [MC_CNT_W-1:0] mc_cnt, mc_cnt_nxt;
  logic                timeout_q, timeout_nxt;

  logic mem_stall, mc_pending, in_mc, mc_release, mc_expire, mc_stall;
  logic load_use;

  assign mem_stall  = mem_req && !mem_ack;
  assign mc_pending = exe_mc_start && !exe_mc_done;
  assign in_mc      = (state == ST_MC_WAIT);
  // The last counted cycle releases the pipeline even without done.
  assign mc_expire  = in_mc && !exe_mc_done && (mc_cnt == MC_LAST);
  assign mc_release = in_mc && (exe_mc_done || (mc_cnt == MC_LAST));
  assign mc_stall   = in_mc ? !mc_release : mc_pending;

  assign load_use = exe_memr && exe_regw && (exe_rd != 5'd0) &&
                    ((dec_use_rs1 && (dec_rs1 == exe_rd)) ||
                     (dec_use_rs2 && (dec_rs2 == exe_rd)));

  assign dbg_state  = state;
  assign mc_timeout = timeout_q && !reset;

  // Control vector. MEM_WAIT needs no special case: while the access is
  // outstanding mem_stall holds it, and on the ack cycle it behaves as RUN.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_exe_en    = 1'b1;
    id_exe_flush = 1'b0;
    exe_mem_en   = 1'b1;
    mem_wb_en    = 1'b1;
    mem_wb_flush = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      if_id_en   = 1'b0;
      id_exe_en  = 1'b0;
      exe_mem_en = 1'b0;
      mem_wb_en  = 1'b0;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_en    = 1'b0;
      exe_mem_en   = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mc_stall) begin
      // exe_mem keeps advancing; the EX control bits are gated upstream so
      // it receives a bubble while the op is in progress.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_exe_en = 1'b0;
    end else if (exe_redirect) begin
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_exe_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    mc_cnt_nxt  = mc_cnt;
    timeout_nxt = timeout_q;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_stall) begin
          state_nxt = ST_MEM_WAIT;
        end else if (mc_pending) begin
          state_nxt  = ST_MC_WAIT;
          mc_cnt_nxt = '0;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_MC_WAIT: begin
        // A memory stall freezes the multi-cycle bookkeeping entirely.
        if (!mem_stall) begin
          if (mc_release) begin
            state_nxt  = ST_RUN;
            mc_cnt_nxt = '0;
            if (mc_expire) timeout_nxt = 1'b1;
          end else if (mc_cnt != CNT_SAT) begin
            mc_cnt_nxt = mc_cnt + MC_CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt  = ST_RUN;
        mc_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      mc_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      mc_cnt    <= mc_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (!pc_en)      perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (if_id_flush) perf_flush_count  <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
// Testbench for pipe_hazard_ctrl: a single-cycle vector table plus
// hand-written multi-cycle sequences, checked through an expected queue.
module tb_pipe_hazard_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic clk;
  logic reset;
  logic [4:0] dec_rs1, dec_rs2, exe_rd;
  logic dec_use_rs1, dec_use_rs2, exe_memr, exe_regw, exe_redirect;
  logic exe_mc_start, exe_mc_done, mem_req, mem_ack;
  logic pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
  logic exe_mem_en, mem_wb_en, mem_wb_flush, mc_timeout;
  logic [1:0] dbg_state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MC_MAX_CYCLES(64), .MC_CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .exe_rd(exe_rd), .exe_memr(exe_memr), .exe_regw(exe_regw),
    .exe_redirect(exe_redirect), .exe_mc_start(exe_mc_start),
    .exe_mc_done(exe_mc_done), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_exe_en(id_exe_en), .id_exe_flush(id_exe_flush),
    .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
    .mem_wb_flush(mem_wb_flush), .mc_timeout(mc_timeout),
    .dbg_state(dbg_state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count)
`endif
  );

  // Control vector order: pc_en, if_id_en, if_id_flush, id_exe_en,
  // id_exe_flush, exe_mem_en, mem_wb_en, mem_wb_flush
  localparam logic [7:0] C_RUN   = 8'b1101_0110;
  localparam logic [7:0] C_REDIR = 8'b1111_1110;
  localparam logic [7:0] C_LU    = 8'b0001_1110;
  localparam logic [7:0] C_MEM   = 8'b0000_0011;
  localparam logic [7:0] C_MC    = 8'b0000_0110;
  localparam logic [7:0] C_RST   = 8'b0000_0000;

  localparam logic [1:0] S_RUN = 2'd0, S_MC = 2'd1, S_MEM = 2'd2;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       memr;
    logic       regw;
    logic       redir;
    logic       mc_start;
    logic       mc_done;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] ctrl;
  } vec_t;

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [10:0] chk_got, chk_exp;
  string       chk_tag;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      chk_exp = exp_q.pop_front();
      chk_tag = tag_q.pop_front();
      chk_got = {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
                 exe_mem_en, mem_wb_en, mem_wb_flush, mc_timeout, dbg_state};
      n_checks++;
      if (chk_got !== chk_exp) begin
        n_fails++;
        $display("FAIL %s: got ctrl=%b to=%b st=%0d, expected ctrl=%b to=%b st=%0d",
                 chk_tag, chk_got[10:3], chk_got[2], chk_got[1:0],
                 chk_exp[10:3], chk_exp[2], chk_exp[1:0]);
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t dec(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic use1, input logic use2,
                              input logic [4:0] rd, input logic memr,
                              input logic regw);
    in_t v;
    v = '0;
    v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
    v.rd = rd; v.memr = memr; v.regw = regw;
    return v;
  endfunction

  task automatic apply(input in_t v);
    reset        = v.rst;
    dec_rs1      = v.rs1;
    dec_rs2      = v.rs2;
    dec_use_rs1  = v.use1;
    dec_use_rs2  = v.use2;
    exe_rd       = v.rd;
    exe_memr     = v.memr;
    exe_regw     = v.regw;
    exe_redirect = v.redir;
    exe_mc_start = v.mc_start;
    exe_mc_done  = v.mc_done;
    mem_req      = v.req;
    mem_ack      = v.ack;
  endtask

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic step(input in_t v, input logic [7:0] ctrl, input logic to,
                      input logic [1:0] st, input string tag);
    @(posedge clk);
    #1;
    apply(v);
    exp_q.push_back({ctrl, to, st});
    tag_q.push_back(tag);
  endtask

  task automatic direct_check(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  vec_t tbl[13];
  in_t  v;
  int   stall_seen;

  initial begin
    // ---- vector table, all applied from RUN ----
    tbl[0]  = '{idle(), C_RUN};
    tbl[1]  = '{dec(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1), C_LU};
    tbl[2]  = '{idle(), C_RUN};
    tbl[3]  = '{dec(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1), C_RUN};
    tbl[4]  = '{dec(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1), C_LU};
    tbl[5]  = '{dec(5'd3, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1), C_RUN};
    tbl[6]  = '{dec(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0), C_RUN};
    tbl[7]  = '{dec(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1), C_RUN};
    tbl[8]  = '{idle(), C_REDIR};
    tbl[8].in.redir = 1'b1;
    tbl[9]  = '{dec(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1), C_REDIR};
    tbl[9].in.redir = 1'b1;
    tbl[10] = '{idle(), C_RUN};
    tbl[10].in.mc_start = 1'b1;
    tbl[10].in.mc_done  = 1'b1;
    tbl[11] = '{idle(), C_RUN};
    tbl[11].in.req = 1'b1;
    tbl[11].in.ack = 1'b1;
    tbl[12] = '{dec(5'd12, 5'd13, 1'b1, 1'b1, 5'd14, 1'b1, 1'b1), C_RUN};

    // ---- reset: first cycle unchecked (state unknown), second checked ----
    v = idle(); v.rst = 1'b1; v.req = 1'b1; v.redir = 1'b1;
    apply(v);
    @(posedge clk);
    step(v, C_RST, 1'b0, S_RUN, "reset_outputs");

    for (int i = 0; i < 13; i++)
      step(tbl[i].in, tbl[i].ctrl, 1'b0, S_RUN, $sformatf("vec%0d", i));

    // Random non-matching decode operands never stall.
    for (int i = 0; i < 4; i++) begin
      v = dec(5'($urandom_range(1, 15)), 5'($urandom_range(1, 15)), 1'b1, 1'b1,
              5'($urandom_range(16, 31)), 1'b1, 1'b1);
      step(v, C_RUN, 1'b0, S_RUN, $sformatf("rand_nomatch%0d", i));
    end

    // ---- mem wait: 3 stall cycles with a pending redirect, then ack ----
    v = idle(); v.req = 1'b1; v.redir = 1'b1;
    step(v, C_MEM, 1'b0, S_RUN, "mem_stall0");
    step(v, C_MEM, 1'b0, S_MEM, "mem_stall1");
    step(v, C_MEM, 1'b0, S_MEM, "mem_stall2");
    v.ack = 1'b1;
    step(v, C_REDIR, 1'b0, S_MEM, "mem_ack_redirect");
    step(idle(), C_RUN, 1'b0, S_RUN, "mem_back_to_run");

    // ---- multi-cycle op done after 10 cycles, redirect ignored while held ----
    v = idle(); v.mc_start = 1'b1;
    step(v, C_MC, 1'b0, S_RUN, "mc_start");
    for (int i = 1; i < 10; i++) begin
      v = idle(); v.redir = (i == 5);
      step(v, C_MC, 1'b0, S_MC, $sformatf("mc_wait%0d", i));
    end
    v = idle(); v.mc_done = 1'b1;
    step(v, C_RUN, 1'b0, S_MC, "mc_done");
    step(idle(), C_RUN, 1'b0, S_RUN, "mc_after_done");

    // ---- mem stall inside MC_WAIT keeps MC_WAIT ----
    v = idle(); v.mc_start = 1'b1;
    step(v, C_MC, 1'b0, S_RUN, "mcm_start");
    step(idle(), C_MC, 1'b0, S_MC, "mcm_wait1");
    step(idle(), C_MC, 1'b0, S_MC, "mcm_wait2");
    v = idle(); v.req = 1'b1;
    step(v, C_MEM, 1'b0, S_MC, "mcm_mem0");
    step(v, C_MEM, 1'b0, S_MC, "mcm_mem1");
    v.ack = 1'b1;
    step(v, C_MC, 1'b0, S_MC, "mcm_mem_ack");
    v = idle(); v.mc_done = 1'b1;
    step(v, C_RUN, 1'b0, S_MC, "mcm_done");
    step(idle(), C_RUN, 1'b0, S_RUN, "mcm_run");

    // ---- timeout: 64 stall cycles, then release and sticky flag ----
    stall_seen = 0;
    v = idle(); v.mc_start = 1'b1;
    step(v, C_MC, 1'b0, S_RUN, "to_start");
    stall_seen++;
    for (int i = 0; i < 63; i++) begin
      step(idle(), C_MC, 1'b0, S_MC, $sformatf("to_wait%0d", i));
      stall_seen++;
    end
    step(idle(), C_RUN, 1'b0, S_MC, "to_release");
    step(idle(), C_RUN, 1'b1, S_RUN, "to_flag_set");
    direct_check("to_stall_cycles", 32'(stall_seen), 32'd64);

    // ---- reset mid mem stall clears state and the timeout flag ----
    v = idle(); v.req = 1'b1;
    step(v, C_MEM, 1'b1, S_RUN, "rst_mem0");
    step(v, C_MEM, 1'b1, S_MEM, "rst_mem1");
    v.rst = 1'b1;
    step(v, C_RST, 1'b0, S_MEM, "rst_during_stall");
    step(idle(), C_RUN, 1'b0, S_RUN, "rst_after");

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // ---- perf counters: 3-cycle mem stall plus one redirect ----
    v = idle(); v.rst = 1'b1;
    step(v, C_RST, 1'b0, S_RUN, "perf_reset");
    v = idle(); v.req = 1'b1;
    step(v, C_MEM, 1'b0, S_RUN, "perf_mem0");
    step(v, C_MEM, 1'b0, S_MEM, "perf_mem1");
    step(v, C_MEM, 1'b0, S_MEM, "perf_mem2");
    v.ack = 1'b1; v.redir = 1'b1;
    step(v, C_REDIR, 1'b0, S_MEM, "perf_ack_redirect");
    step(idle(), C_RUN, 1'b0, S_RUN, "perf_idle");
    @(negedge clk);
    direct_check("perf_stall_cycles", perf_stall_cycles, 32'd3);
    direct_check("perf_flush_count", perf_flush_count, 32'd1);
`endif

    // ---- drain, bounded ----
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
